// File: rtl/instr_encoder_loader_pkg.sv
// Shared types for the instruction encoder/loader: request format, FSM states,
// RV32I opcode constants and immediate range limits.
package instr_encoder_loader_pkg;

    localparam int ADDR_WIDTH = 9;
    localparam int MEM_SIZE   = 512;

    localparam logic [6:0] OP_R_TYPE       = 7'h33;
    localparam logic [6:0] OP_RV64_TYPE    = 7'h3B;
    localparam logic [6:0] OP_I_TYPE_LOAD  = 7'h03;
    localparam logic [6:0] OP_I_TYPE_ARITH = 7'h13;
    localparam logic [6:0] OP_S_TYPE       = 7'h23;
    localparam logic [6:0] OP_B_TYPE       = 7'h63;
    localparam logic [6:0] OP_J_TYPE       = 7'h6F;

    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;

    typedef struct packed {
        logic [6:0]         op;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        logic signed [31:0] imm;
    } enc_req_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE,
        ST_ERROR
    } enc_state_e;

    function automatic logic imm_in_range(input logic signed [31:0] imm, input int lo, input int hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// Combinational RV32I bit packer. Immediate range checks are compiled in only
// when ENCODE_RANGE_CHECK_EN is defined; otherwise immediates are truncated.
module instr_pack
    import instr_encoder_loader_pkg::*;
(
    input  enc_req_t    req,
    output logic [31:0] word,
    output logic        fmt_err
);

    logic [31:0] imm;
    assign imm = req.imm;

    always_comb begin
        word    = '0;
        fmt_err = 1'b0;
        case (req.op)
            OP_R_TYPE, OP_RV64_TYPE:
                word = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.op};
            OP_I_TYPE_LOAD, OP_I_TYPE_ARITH: begin
                // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
                if (req.op == OP_I_TYPE_ARITH && (req.funct3 == F3_SLL || req.funct3 == F3_SRL_SRA))
                    word = {req.funct7, imm[4:0], req.rs1, req.funct3, req.rd, req.op};
                else
                    word = {imm[11:0], req.rs1, req.funct3, req.rd, req.op};
`ifdef ENCODE_RANGE_CHECK_EN
                fmt_err = !imm_in_range(req.imm, IMM_I_MIN, IMM_I_MAX);
`endif
            end
            OP_S_TYPE: begin
                word = {imm[11:5], req.rs2, req.rs1, req.funct3, imm[4:0], req.op};
`ifdef ENCODE_RANGE_CHECK_EN
                fmt_err = !imm_in_range(req.imm, IMM_I_MIN, IMM_I_MAX);
`endif
            end
            OP_B_TYPE: begin
                word = {imm[12], imm[10:5], req.rs2, req.rs1, req.funct3, imm[4:1], imm[11], req.op};
`ifdef ENCODE_RANGE_CHECK_EN
                fmt_err = !imm_in_range(req.imm, IMM_B_MIN, IMM_B_MAX) || imm[0];
`endif
            end
            OP_J_TYPE: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, req.op};
`ifdef ENCODE_RANGE_CHECK_EN
                fmt_err = !imm_in_range(req.imm, IMM_J_MIN, IMM_J_MAX) || imm[0];
`endif
            end
            default: fmt_err = 1'b1;
        endcase
    end

`ifndef ENCODE_RANGE_CHECK_EN
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[31:21];
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Session-based instruction loader: encodes requests into RV32I words, queues them
// in a small FIFO and writes them to consecutive memory words. Optional macro:
// ENCODE_RANGE_CHECK_EN (immediate range checks in instr_pack).
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  enc_req_t              in_req,
    input  logic                  in_last,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    typedef logic [PW-1:0]         ptr_t;
    typedef logic [OW-1:0]         occ_t;
    typedef logic [ADDR_WIDTH+1:0] sum_t;

    enc_state_e            state_q;
    logic [31:0]           fifo_q [FIFO_DEPTH];
    ptr_t                  wr_ptr_q, rd_ptr_q;
    occ_t                  occ_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  done_q, err_q;

    logic [31:0] enc_word;
    logic        fmt_err, accept, cap_err, enc_err, push, pop;

    function automatic ptr_t next_ptr(input ptr_t p);
        return (p == ptr_t'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    instr_pack u_pack (
        .req     (in_req),
        .word    (enc_word),
        .fmt_err (fmt_err)
    );

    assign in_ready = (state_q == ST_LOAD) && (occ_q < occ_t'(FIFO_DEPTH));
    assign mem_we   = ((state_q == ST_LOAD) || (state_q == ST_DRAIN)) && (occ_q != '0);
    assign accept   = in_valid && in_ready;
    // Words already queued count against capacity, not just words written.
    assign cap_err  = (sum_t'(count_q) + sum_t'(occ_q)) == sum_t'(MEM_SIZE);
    assign enc_err  = accept && (fmt_err || cap_err);
    assign push     = accept && !enc_err;
    assign pop      = mem_we && mem_ready;

    assign mem_wdata = mem_we ? fifo_q[rd_ptr_q] : '0;
    assign mem_addr  = addr_q;
    assign count     = count_q;
    assign done      = done_q;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= enc_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            addr_q   <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
                addr_q   <= addr_q + 1'b1;
                count_q  <= count_q + 1'b1;
            end
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            occ_q <= occ_q + occ_t'(push) - occ_t'(pop);

            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_q <= ST_LOAD;
                        addr_q  <= base_addr;
                        count_q <= '0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (enc_err) begin
                        state_q  <= ST_ERROR;
                        err_q    <= 1'b1;
                        occ_q    <= '0;
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                    end else if (push && in_last) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (occ_q == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: table of encodings plus hand-written
// sequences for wrap, backpressure, errors, capacity and mid-session reset.
module tb_instr_encoder_loader;
    import instr_encoder_loader_pkg::*;

    logic                  clk, rst_n, start, in_valid, in_ready, in_last;
    logic                  mem_we, mem_ready, done, err;
    logic [ADDR_WIDTH-1:0] base_addr, mem_addr;
    logic [31:0]           mem_wdata;
    logic [ADDR_WIDTH:0]   count;
    enc_req_t              in_req;

    instr_encoder_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_req(in_req), .in_last(in_last),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .done(done), .err(err), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        enc_req_t    req;
        logic [31:0] exp;
    } vec_t;

    vec_t                             vecs [8];
    logic [ADDR_WIDTH+31:0]           wq [$];
    int                               n_chk = 0;
    int                               n_pass = 0;

    // Every memory handshake the DUT will see at the coming rising edge.
    always @(negedge clk) begin
        #2;
        if (rst_n && mem_we && mem_ready) wq.push_back({mem_addr, mem_wdata});
    end

    function automatic enc_req_t mk(input int op, input int rd, input int rs1, input int rs2,
                                    input int f3, input int f7, input int imm);
        enc_req_t r;
        r.op = 7'(op); r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
        r.funct3 = 3'(f3); r.funct7 = 7'(f7); r.imm = imm;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic start_session(input logic [ADDR_WIDTH-1:0] base);
        start = 1'b1; base_addr = base;
        @(negedge clk);
        start = 1'b0;
        wq.delete();
    endtask

    task automatic send(input enc_req_t r, input logic last);
        int n;
        n = 0;
        in_req = r; in_last = last; in_valid = 1'b1;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("send_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_end(input string name, input int max);
        int n;
        n = 0;
        while (!done && !err && n < max) begin @(negedge clk); n++; end
        chk(name, 64'(done | err), 64'd1);
    endtask

    function automatic logic [ADDR_WIDTH+31:0] wq_at(input int i);
        return (i < wq.size()) ? wq[i] : '1;
    endfunction

    initial begin
        enc_req_t add_r, addi_r, bad_r, b3_r;
        int k;
        logic acc;
        add_r  = mk('h33, 3, 1, 2, 0, 0, 0);
        addi_r = mk('h13, 5, 0, 0, 0, 0, -1);
        bad_r  = mk('h7F, 1, 1, 1, 0, 0, 0);
        b3_r   = mk('h63, 0, 1, 2, 0, 0, 3);
        vecs[0] = '{addi_r,                           32'hFFF00293};
        vecs[1] = '{mk('h63, 0, 1, 2, 0, 0, 8),       32'h00208463};
        vecs[2] = '{mk('h6F, 1, 0, 0, 0, 0, 2048),    32'h001000EF};
        vecs[3] = '{mk('h23, 0, 1, 2, 2, 0, 12),      32'h0020A623};
        vecs[4] = '{mk('h13, 4, 4, 0, 5, 'h20, 3),    32'h40325213};
        vecs[5] = '{mk('h03, 6, 2, 0, 2, 0, -4),      32'hFFC12303};
        vecs[6] = '{mk('h3B, 7, 1, 2, 0, 0, 0),       32'h002083BB};
        vecs[7] = '{mk('h63, 0, 1, 2, 1, 0, -4),      32'hFE209EE3};

        rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_last = 1'b0; in_req = '0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", 64'({mem_we, in_ready, done, err, mem_addr, mem_wdata}), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single ADD: encoded word appears one cycle after acceptance.
        mem_ready = 1'b1;
        start_session(9'h010);
        in_req = add_r; in_last = 1'b1; in_valid = 1'b1;
        chk("add_in_ready", 64'(in_ready), 64'd1);
        chk("add_no_we_at_accept", 64'(mem_we), 64'd0);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("add_we_next", 64'(mem_we), 64'd1);
        chk("add_word", 64'({mem_addr, mem_wdata}), 64'({9'h010, 32'h002081B3}));
        wait_end("add_end", 50);
        chk("add_done_err", 64'({done, err}), 64'b10);
        chk("add_count", 64'(count), 64'd1);
        chk("add_nwrites", 64'(wq.size()), 64'd1);

        // Encoding table, one session at consecutive addresses.
        start_session(9'h020);
        for (int i = 0; i < 8; i++) send(vecs[i].req, i == 7);
        wait_end("tbl_end", 100);
        chk("tbl_done_err", 64'({done, err}), 64'b10);
        chk("tbl_count", 64'(count), 64'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("tbl_vec%0d", i), 64'(wq_at(i)), 64'({9'(9'h020 + i), vecs[i].exp}));

        // Address wrap at the top of memory.
        start_session(9'h1FF);
        send(add_r, 1'b0);
        send(addi_r, 1'b1);
        wait_end("wrap_end", 50);
        chk("wrap_count", 64'(count), 64'd2);
        chk("wrap_w0", 64'(wq_at(0)), 64'({9'h1FF, 32'h002081B3}));
        chk("wrap_w1", 64'(wq_at(1)), 64'({9'h000, 32'hFFF00293}));

        // Backpressure: memory stalled for 6 cycles while 4 requests are offered.
        start_session(9'h040);
        mem_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            in_req = vecs[k].req; in_last = (k == 3); in_valid = 1'b1;
            acc = in_ready;
            @(negedge clk);
            if (acc) k++;
        end
        chk("bp_accepted", 64'(k), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_held", 64'({mem_we, mem_addr, mem_wdata}), 64'({1'b1, 9'h040, vecs[0].exp}));
        mem_ready = 1'b1;
        for (int c = 0; c < 50 && k < 4; c++) begin
            in_req = vecs[k].req; in_last = (k == 3); in_valid = 1'b1;
            acc = in_ready;
            @(negedge clk);
            if (acc) k++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        wait_end("bp_end", 50);
        chk("bp_nwrites", 64'(wq.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("bp_w%0d", i), 64'(wq_at(i)), 64'({9'(9'h040 + i), vecs[i].exp}));

        // Unknown opcode aborts the session; earlier word stays written.
        start_session(9'h080);
        chk("restart_clears_done", 64'({done, err}), 64'd0);
        send(add_r, 1'b0);
        repeat (3) @(negedge clk);
        send(bad_r, 1'b0);
        repeat (3) @(negedge clk);
        chk("op_err_flags", 64'({done, err, in_ready, mem_we}), 64'b0100);
        chk("op_err_count", 64'(count), 64'd1);
        chk("op_err_nwrites", 64'(wq.size()), 64'd1);

        // Misaligned branch offset.
        start_session(9'h090);
        chk("restart_clears_err", 64'(err), 64'd0);
        send(b3_r, 1'b1);
        wait_end("b3_end", 50);
`ifdef ENCODE_RANGE_CHECK_EN
        chk("b3_err", 64'({done, err}), 64'b01);
        chk("b3_nwrites", 64'(wq.size()), 64'd0);
`else
        chk("b3_done", 64'({done, err}), 64'b10);
        chk("b3_word", 64'(wq_at(0)), 64'({9'h090, 32'h00208163}));
`endif

        // Capacity: the 513th word of a session is an error.
        start_session(9'h000);
        for (int i = 0; i < MEM_SIZE; i++) send(add_r, 1'b0);
        repeat (4) @(negedge clk);
        chk("cap_full_count", 64'(count), 64'd512);
        chk("cap_full_err", 64'(err), 64'd0);
        send(add_r, 1'b0);
        repeat (2) @(negedge clk);
        chk("cap_err", 64'(err), 64'd1);
        chk("cap_nwrites", 64'(wq.size()), 64'd512);

        // Asynchronous reset in DRAIN with two words queued.
        start_session(9'h100);
        send(add_r, 1'b0);
        repeat (2) @(negedge clk);
        mem_ready = 1'b0;
        send(addi_r, 1'b0);
        send(vecs[2].req, 1'b1);
        chk("drain_state", 64'(dut.state_q), 64'(ST_DRAIN));
        chk("drain_pre", 64'({mem_we, count}), 64'({1'b1, 10'd1}));
        #3 rst_n = 1'b0;
        #1;
        chk("rst_outs", 64'({mem_we, in_ready, done, err, mem_addr, mem_wdata}), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
